// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch queue.
package fetch_pkg;

  localparam int FQ_DATA_WIDTH = 32;
  localparam int FQ_DEPTH      = 4;
  localparam int FQ_PTR_W      = $clog2(FQ_DEPTH);

  // One fetched packet as it travels from the IF stage to decode.
  typedef struct packed {
    logic [FQ_DATA_WIDTH-1:0] instr;
    logic [FQ_DATA_WIDTH-1:0] pc;
    logic [FQ_DATA_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of IF-side, instruction-memory and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);

  logic [DATA_WIDTH-1:0]      pc_i;
  logic [DATA_WIDTH-1:0]      pc_plus4_i;
  logic                       pc_we_o;
  logic [DATA_WIDTH-1:0]      imem_rdata_i;
  logic                       flush_i;
  logic                       id_valid_o;
  logic                       id_ready_i;
  logic [DATA_WIDTH-1:0]      id_instr_o;
  logic [DATA_WIDTH-1:0]      id_pc_o;
  logic [DATA_WIDTH-1:0]      id_pc_plus4_o;
  logic [$clog2(DEPTH):0]     count_o;

  // Environment side: IF stage, instruction memory and decode.
  modport master (
    output pc_i, pc_plus4_i, imem_rdata_i, flush_i, id_ready_i,
    input  pc_we_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, count_o
  );

  // The fetch queue itself.
  modport slave (
    input  pc_i, pc_plus4_i, imem_rdata_i, flush_i, id_ready_i,
    output pc_we_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, count_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous clear; DEPTH must be a power of two.
module sync_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IF and decode: issues credit-limited fetches, captures the
// one-cycle-late memory response with its PC pair, and hands packets to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = FQ_DATA_WIDTH,
  parameter int DEPTH      = FQ_DEPTH
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] req_pc4_q;
  logic                  pc_we;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        occupancy;
  fetch_entry_t          wr_entry;
  fetch_entry_t          rd_entry;

  assign pop  = bus.id_valid_o & bus.id_ready_i;
  assign push = inflight_q & ~bus.flush_i;

  // One extra bit so occupancy can never alias; pop implies count >= 1, so no underflow.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign pc_we     = ~rst & ~bus.flush_i & (occupancy < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= pc_we;
  end

  always_ff @(posedge clk) begin
    if (pc_we) begin
      req_pc_q  <= bus.pc_i;
      req_pc4_q <= bus.pc_plus4_i;
    end
  end

  assign wr_entry = '{instr: bus.imem_rdata_i, pc: req_pc_q, pc_plus4: req_pc4_q};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush_i),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  assign bus.pc_we_o       = pc_we;
  assign bus.count_o       = count;
  assign bus.id_valid_o    = (count != '0);
  assign bus.id_instr_o    = bus.id_valid_o ? rd_entry.instr    : '0;
  assign bus.id_pc_o       = bus.id_valid_o ? rd_entry.pc       : '0;
  assign bus.id_pc_plus4_o = bus.id_valid_o ? rd_entry.pc_plus4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-plus-random bench for fetch_queue with a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fq_bus ();

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fq_bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued packets plus at most one outstanding fetch.
  fetch_entry_t mq[$];
  bit           m_inflight;
  fetch_entry_t m_pending;

  logic [31:0] pc;
  int          cyc = 0;
  int          pops = 0;
  bit          have_last;
  logic [31:0] last_pc;

  bit          s_we, s_valid;
  int          s_count;
  logic [31:0] s_pc, s_instr;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs for this cycle are already set by the caller.
  task automatic step();
    fetch_entry_t head;
    bit          m_valid, m_pop, m_we, issued;
    int          occ;
    logic [31:0] issued_pc;
    fq_bus.pc_i       = pc;
    fq_bus.pc_plus4_i = pc + 32'd4;
    #1;
    m_valid = (mq.size() != 0);
    head    = m_valid ? mq[0] : '0;
    m_pop   = m_valid && fq_bus.id_ready_i;
    occ     = mq.size() + int'(m_inflight) - int'(m_pop);
    m_we    = !rst && !fq_bus.flush_i && (occ < DEPTH);

    s_we    = fq_bus.pc_we_o;
    s_valid = fq_bus.id_valid_o;
    s_count = int'(fq_bus.count_o);
    s_pc    = fq_bus.id_pc_o;
    s_instr = fq_bus.id_instr_o;

    check("pc_we",       32'(fq_bus.pc_we_o),    32'(m_we));
    check("id_valid",    32'(fq_bus.id_valid_o), 32'(m_valid));
    check("count",       32'(fq_bus.count_o),    32'(mq.size()));
    check("id_instr",    fq_bus.id_instr_o,      head.instr);
    check("id_pc",       fq_bus.id_pc_o,         head.pc);
    check("id_pc_plus4", fq_bus.id_pc_plus4_o,   head.pc_plus4);
    check("count_bound", 32'(fq_bus.count_o <= 3'(DEPTH)), 32'd1);
    check("push_when_full",
          32'(dut.push && !dut.pop && fq_bus.count_o == 3'(DEPTH)), 32'd0);

    if (m_pop && !rst && !fq_bus.flush_i) begin
      if (have_last) check("pc_contig", fq_bus.id_pc_o, last_pc + 32'd4);
      have_last = 1'b1;
      last_pc   = fq_bus.id_pc_o;
      pops++;
    end

    if (rst || fq_bus.flush_i) begin
      mq.delete();
      m_inflight = 1'b0;
      have_last  = 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_pending);
      m_inflight = m_we;
      if (m_we) m_pending = '{instr: 32'h1000_0000 | pc, pc: pc, pc_plus4: pc + 32'd4};
    end

    issued    = fq_bus.pc_we_o;
    issued_pc = pc;
    @(posedge clk);
    cyc++;
    #1;
    fq_bus.imem_rdata_i = issued ? (32'h1000_0000 | issued_pc) : $urandom();
    if (issued) pc = pc + 32'd4;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_we, first_valid, n_we;
    logic [31:0] first_pc, flushed_pc;
    bit          found;

    rst                 = 1'b1;
    pc                  = '0;
    fq_bus.flush_i      = 1'b0;
    fq_bus.id_ready_i   = 1'b0;
    fq_bus.imem_rdata_i = '0;
    fq_bus.pc_i         = '0;
    fq_bus.pc_plus4_i   = 32'd4;

    // Reset state and pc_we held low while in reset.
    step();
    step();
    check("rst_we_low", 32'(s_we), 32'd0);
    check("rst_count",  32'(fq_bus.count_o), 32'd0);
    rst = 1'b0;

    // Streaming with decode always ready.
    fq_bus.id_ready_i = 1'b1;
    first_we = -1; first_valid = -1; first_pc = 32'hffff_ffff;
    repeat (12) begin
      step();
      if (s_we && first_we < 0) first_we = cyc - 1;
      if (s_valid && first_valid < 0) begin
        first_valid = cyc - 1;
        first_pc    = s_pc;
      end
    end
    check("fetch_latency", 32'(first_valid - first_we), 32'd2);
    check("first_pc",      first_pc, 32'h0);

    // Backpressure from a fresh reset.
    rst = 1'b1; pc = '0;
    step();
    rst = 1'b0;
    fq_bus.id_ready_i = 1'b0;
    n_we = 0;
    repeat (8) begin
      step();
      n_we += int'(s_we);
    end
    check("bp_we_cycles", 32'(n_we), 32'd4);
    check("bp_full",      32'(s_count), 32'd4);
    fq_bus.id_ready_i = 1'b1;
    step();
    check("bp_release_we", 32'(s_we), 32'd1);
    fq_bus.id_ready_i = 1'b0;
    repeat (3) step();
    check("bp_refill", 32'(s_count), 32'd4);

    // Full queue with alternating ready: simultaneous push and pop.
    for (int i = 0; i < 24; i++) begin
      fq_bus.id_ready_i = i[0];
      step();
    end

    // Flush with three queued and one in flight.
    rst = 1'b1; pc = '0;
    fq_bus.id_ready_i = 1'b0;
    step();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (fq_bus.count_o == 3'd3 && dut.inflight_q) found = 1'b1;
    end
    check("flush_setup", 32'(found), 32'd1);
    flushed_pc = pc - 32'd4;
    fq_bus.flush_i = 1'b1;
    step();
    fq_bus.flush_i = 1'b0;
    check("flush_count", 32'(fq_bus.count_o),    32'd0);
    check("flush_valid", 32'(fq_bus.id_valid_o), 32'd0);
    fq_bus.id_ready_i = 1'b1;
    repeat (10) begin
      step();
      check("flush_drop", 32'(s_valid && s_pc == flushed_pc), 32'd0);
    end

    // Reset mid-stream with two entries queued.
    fq_bus.id_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (fq_bus.count_o == 3'd2) found = 1'b1;
    end
    check("rst_mid_setup", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_we", 32'(s_we), 32'd0);
    check("rst_mid_count", 32'(fq_bus.count_o),    32'd0);
    check("rst_mid_valid", 32'(fq_bus.id_valid_o), 32'd0);
    step();
    check("rst_mid_we2", 32'(s_we), 32'd0);
    rst = 1'b0;
    pc  = '0;

    // Wrap-around: at least ten packets through the ring with random ready.
    pops = 0;
    for (int i = 0; i < 300 && pops < 10; i++) begin
      fq_bus.id_ready_i = 1'($urandom_range(0, 1));
      step();
      if (!s_valid) check("idle_instr_zero", s_instr, 32'h0);
    end
    check("wrap_pops", 32'(pops >= 10), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
